// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port arbiter for core writeback and photon writes
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     core_we,
  input  logic [4:0]               core_rd,
  input  logic [31:0]              core_wdata,
  input  logic                     mem_hold,
  input  logic                     ph_valid,
  output logic                     ph_ready,
  input  logic [4:0]               ph_rd,
  input  logic [31:0]              ph_wdata,
  output logic                     reg_we,
  output logic [4:0]               reg_waddr,
  output logic [31:0]              reg_wdata,
  output logic                     core_stall,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [7:0]    starve_cnt;
  logic [DEPTH-1:0] entry_valid;

  logic head_valid;
  logic core_ok;
  logic drain;
  logic enq;

  assign ph_ready   = (count < CW'(DEPTH));
  assign head_valid = (count != '0);
  // core_stall comes straight from a flop compare, so it carries no input-path glitches
  assign core_stall = (starve_cnt == LIMIT);
  // Rst gating keeps the write port quiet while the block is held in reset
  assign core_ok    = core_we & (core_rd != 5'd0) & ~mem_hold & ~core_stall & ~Rst;
  assign drain      = head_valid & (core_stall | ~core_ok);
  assign enq        = ph_valid & ph_ready & (ph_rd != 5'd0);
  assign fifo_count = count;

  // Single write port: core first unless a forced photon drain is due
  always_comb begin
    reg_we    = 1'b0;
    reg_waddr = 5'd0;
    reg_wdata = 32'd0;
    if (core_ok) begin
      reg_we    = 1'b1;
      reg_waddr = core_rd;
      reg_wdata = core_wdata;
    end else if (drain) begin
      reg_we    = 1'b1;
      reg_waddr = mem_rd[rptr];
      reg_wdata = mem_data[rptr];
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, AW'(i) - rptr} < count);
    end
  end

  // Scoreboard: one bit per register with any live photon write outstanding
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending[mem_rd[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  // FIFO storage; contents need no reset because occupancy gates every use
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wptr]   <= ph_rd;
      mem_data[wptr] <= ph_wdata;
    end
  end

  // Pointers and occupancy; enqueue and drain in one cycle leave count unchanged
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq)   wptr <= wptr + 1'b1;
      if (drain) rptr <= rptr + 1'b1;
      if (enq && !drain)      count <= count + 1'b1;
      else if (!enq && drain) count <= count - 1'b1;
    end
  end

  // Starvation counter: counts blocked cycles with a waiting head, saturating at the limit
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      starve_cnt <= 8'd0;
    end else if (!head_valid || drain) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sits directly upstream of the integer register file and owns its single write port.
- Merges two write sources:
  - the core MEM/WB writeback;
  - buffered write requests from the photon accelerator.
- Provides a pending-write scoreboard so the hazard unit can stall reads of registers with photon writes still in flight.
- Prevents photon starvation by inserting a one-cycle core stall after a bounded wait.

Parameters:
- DEPTH, 4: photon write FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive blocked cycles with a non-empty FIFO before core_stall is forced; 1..255.

Ports:
- clk  in  1  core clock
- Rst  in  1  asynchronous active-high reset
- core_we  in  1  MEM_WB regwrite
- core_rd  in  5  MEM_WB destination register
- core_wdata  in  32  WB result
- mem_hold  in  1  memory hold; suppresses the core write this cycle
- ph_valid  in  1  photon write request valid
- ph_ready  out  1  FIFO can accept a request
- ph_rd  in  5  photon destination register
- ph_wdata  in  32  photon data
- reg_we  out  1  register file write enable
- reg_waddr  out  5  register file write address
- reg_wdata  out  32  register file write data
- core_stall  out  1  upstream must hold its MEM/WB write this cycle
- pending  out  32  bit i = 1 if any valid FIFO entry targets register i
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, Rst=1):
  - FIFO pointers, count and starve counter go to 0.
  - Outputs: ph_ready=1, reg_we=0, reg_waddr=0, reg_wdata=0, core_stall=0, pending=0, fifo_count=0.
  - Reset mid-operation discards all queued photon writes; none reach the register file.
- core_ok = core_we & (core_rd≠0) & ~mem_hold & ~core_stall.
- Enqueue:
  - Occurs on posedge when ph_valid & ph_ready & (ph_rd≠0).
  - ph_ready = (count < DEPTH), a function of registered count only.
  - Requests to x0 are accepted (handshake completes) but not stored.
- Drain:
  - head_valid = (count≠0).
  - drain = head_valid & (core_stall | ~core_ok).
- Write port (combinational, same cycle; the register file samples at posedge):
  - If core_ok: reg_we=1, reg_waddr=core_rd, reg_wdata=core_wdata.
  - Else if drain: reg_we=1, address/data taken from the FIFO head.
  - Else: reg_we=0; address/data are don't-care, driven 0.
- Priority: the core write wins unless core_stall=1. At most one write per cycle.
- Simultaneous enqueue and drain: count is unchanged, pointers both advance. Allowed when full only if the drain frees a slot; since ph_ready is based on the registered count, a full FIFO refuses that cycle.
- Starve counter (8 bits):
  - Increments each cycle head_valid & ~drain, saturating at STARVE_LIMIT.
  - Clears on drain or when the FIFO is empty.
  - core_stall = (starve_cnt == STARVE_LIMIT); registered-source, glitch-free. It stays high exactly one cycle, because drain occurs that cycle and clears the counter.
- Same-register ordering: if the core writes rX while the FIFO head targets rX, the core writes first and the photon value lands later, so the photon value is final. The hazard unit relies on pending[X] to stall dependent reads.
- pending:
  - Combinational OR over valid FIFO entries.
  - Bit 0 is always 0.
  - Duplicates to the same register keep the bit set until the last such entry drains.
- Write pointers wrap modulo DEPTH.
- Occupancy never exceeds DEPTH; an enqueue attempt while full is simply not accepted, with no error.

Test Plan:
- Reset, then photon writes r5=0x11, r6=0x22 with the core idle → reg_we on consecutive cycles: r5=0x11, then r6=0x22. pending[5] and pending[6] drop as each drains; fifo_count 0 afterward.
- Core writes r7=0xAA every cycle while photon enqueues r8=0x55, with STARVE_LIMIT=8 → exactly 8 blocked cycles, then core_stall=1 for one cycle with reg_waddr=8, reg_wdata=0x55; the core write resumes next cycle.
- Fill 4 photon requests with core_we=1 continuous → ph_ready=0 at fifo_count=4. A fifth ph_valid is held until the first forced drain, then accepted; order is preserved across pointer wrap.
- Same-cycle core r9=0x1 and FIFO head r9=0x2 → r9 written 0x1 then 0x2. pending[9]=1 until the second write.
- Photon request to x0, and core write to x0 → handshake completes, fifo_count stays 0, reg_we=0, pending=0.
- Assert Rst asynchronously mid-cycle with 3 entries queued → pending=0, fifo_count=0 and ph_ready=1 immediately; no queued write appears after release.
